// File: rtl/regfile_clr_pkg.sv
// Shared definitions for the regfile_clr register bank.
//   DefWidth / DefAddrW : default data and address widths
//   state_e             : clear-engine FSM state encoding (idle = 0, clear = 1)
package regfile_clr_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefAddrW = 3;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_clr_dec_param.sv
// Enable-gated N-to-2^N one-hot decoder.
//   in : binary select, N bits
//   en : when low, every output is zero
//   y  : one-hot of in when en is high
module dec_param #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]      in,
  input  logic              en,
  output logic [(2**N)-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[in] = 1'b1;
  end

endmodule

// File: rtl/regfile_clr.sv
// Parametrised register file: 2^ADDR_W x WIDTH, one write port, two combinational
// read ports with write-through bypass, optional hard-wired zero register, and a
// sequenced bulk-clear engine.
//   clk, rst          : clock, synchronous active-high reset
//   clr_req           : start a bulk clear (honoured only when idle)
//   busy, clr_done    : clear in progress / one-cycle completion pulse
//   we, waddr, wdata  : write port; wr_ok reports the write was accepted
//   raddr_a/b, rdata_a/b : read ports
module regfile_clr
  import regfile_clr_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              wr_ok,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  localparam int unsigned NReg = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NReg - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              clr_done_q;
  logic [WIDTH-1:0]  mem_q [NReg];
  logic [NReg-1:0]   we_dec;

  assign busy     = (state_q == StClear);
  assign clr_done = clr_done_q;
  assign wr_ok    = we & ~busy;

  dec_param #(
    .N (ADDR_W)
  ) u_wdec (
    .in (waddr),
    .en (wr_ok),
    .y  (we_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      for (int i = 0; i < NReg; i++) mem_q[i] <= '0;
    end else begin
      clr_done_q <= 1'b0;
      // Writes and clearing are mutually exclusive: wr_ok is gated by busy.
      for (int i = 0; i < NReg; i++) begin
        if (we_dec[i] && !((ZERO_REG != 0) && (i == 0))) mem_q[i] <= wdata;
      end
      unique case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q <= StClear;
            cnt_q   <= '0;
          end
        end
        StClear: begin
          mem_q[cnt_q] <= '0;
          // Counter wraps to 0 on the same edge the engine returns to idle.
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_q    <= StIdle;
            clr_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic zero_a, zero_b;
  assign zero_a = (ZERO_REG != 0) && (raddr_a == '0);
  assign zero_b = (ZERO_REG != 0) && (raddr_b == '0);

  always_comb begin
    rdata_a = mem_q[raddr_a];
    if (wr_ok && (raddr_a == waddr)) rdata_a = wdata;
    if (zero_a) rdata_a = '0;
  end

  always_comb begin
    rdata_b = mem_q[raddr_b];
    if (wr_ok && (raddr_b == waddr)) rdata_b = wdata;
    if (zero_b) rdata_b = '0;
  end

endmodule

// File: tb/tb_regfile_clr.sv
module tb_regfile_clr;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst, clr_req, we;
  logic [AW-1:0] waddr, raddr_a, raddr_b;
  logic [W-1:0]  wdata;
  logic          busy, clr_done, wr_ok;
  logic [W-1:0]  rdata_a, rdata_b;
  logic          busy1, clr_done1, wr_ok1;
  logic [W-1:0]  rdata_a1, rdata_b1;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  regfile_clr #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
    .we(we), .waddr(waddr), .wdata(wdata), .wr_ok(wr_ok),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b)
  );

  regfile_clr #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1), .clr_done(clr_done1),
    .we(we), .waddr(waddr), .wdata(wdata), .wr_ok(wr_ok1),
    .raddr_a(raddr_a), .rdata_a(rdata_a1), .raddr_b(raddr_b), .rdata_b(rdata_b1)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [W-1:0]  exp_a;
    logic [W-1:0]  exp_b;
    logic          exp_ok;
    logic [W-1:0]  exp_a_nz;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bcount;
    rst = 1'b1; clr_req = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0;

    vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd7, 8'hA5, 8'h00, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 3'd7, 8'h3C, 3'd3, 3'd7, 8'hA5, 8'h3C, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'hA5, 8'h3C, 1'b0, 8'hA5};
    vecs[3] = '{1'b1, 3'd5, 8'h77, 3'd5, 3'd3, 8'h77, 8'hA5, 1'b1, 8'h77};
    vecs[4] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 8'hFF};
    vecs[5] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd5, 8'h00, 8'h77, 1'b0, 8'hFF};
    vecs[6] = '{1'b1, 3'd5, 8'h12, 3'd5, 3'd5, 8'h12, 8'h12, 1'b1, 8'h12};
    vecs[7] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd7, 8'h12, 8'h3C, 1'b0, 8'h12};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_clr_done", 32'(clr_done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      raddr_a = AW'(i); raddr_b = AW'(7 - i);
      #1;
      chk("reset_rd_a", 32'(rdata_a), 32'd0);
      chk("reset_rd_b", 32'(rdata_b), 32'd0);
    end

    // Write / bypass / zero-register table
    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
      raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
      #1;
      chk($sformatf("vec%0d_rd_a", i), 32'(rdata_a), 32'(vecs[i].exp_a));
      chk($sformatf("vec%0d_rd_b", i), 32'(rdata_b), 32'(vecs[i].exp_b));
      chk($sformatf("vec%0d_wr_ok", i), 32'(wr_ok), 32'(vecs[i].exp_ok));
      chk($sformatf("vec%0d_nz_rd_a", i), 32'(rdata_a1), 32'(vecs[i].exp_a_nz));
      tick();
    end
    we = 1'b0;

    // Fill regs 1..7 with 0x10+i
    for (int i = 1; i < 8; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = W'(8'h10 + i);
      tick();
    end
    we = 1'b0;

    // Clear sequence
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    raddr_a = 3'd6; raddr_b = 3'd2;
    we = 1'b1; waddr = 3'd2; wdata = 8'hEE;
    #1;
    chk("clr_busy_start", 32'(busy), 32'd1);
    chk("clr_wr_ok_blocked", 32'(wr_ok), 32'd0);
    chk("clr_no_bypass", 32'(rdata_b), 32'h12);
    chk("clr_rd6_old", 32'(rdata_a), 32'h16);
    bcount = 1;
    for (int c = 1; c < 20; c++) begin
      tick();
      we = 1'b0;
      clr_req = (c == 2);
      #1;
      if (c == 1) chk("clr_write_dropped", 32'(rdata_b), 32'h12);
      if (c == 3) chk("clr_rd6_mid", 32'(rdata_a), 32'h16);
      if (c == 3) chk("clr_rd0_cleared", 32'(rdata_a1), 32'h16);
      if (!busy) break;
      chk("clr_done_low_while_busy", 32'(clr_done), 32'd0);
      bcount++;
    end
    clr_req = 1'b0;
    chk("clr_busy_cycles", 32'(bcount), 32'd8);
    chk("clr_done_pulse", 32'(clr_done), 32'd1);
    chk("clr_rd6_after", 32'(rdata_a), 32'd0);
    chk("clr_rd2_after", 32'(rdata_b), 32'd0);
    for (int i = 0; i < 8; i++) begin
      raddr_b = AW'(i);
      #1;
      chk("clr_all_zero_nz", 32'(rdata_b1), 32'd0);
    end
    tick();
    chk("clr_done_one_cycle", 32'(clr_done), 32'd0);
    chk("clr_req_not_queued", 32'(busy), 32'd0);

    // Collision with write, then abort by reset on third clear cycle
    we = 1'b1; waddr = 3'd4; wdata = 8'h11; clr_req = 1'b1;
    #1;
    chk("coll_wr_ok", 32'(wr_ok), 32'd1);
    tick();
    we = 1'b0; clr_req = 1'b0; raddr_a = 3'd4;
    #1;
    chk("coll_busy", 32'(busy), 32'd1);
    chk("coll_rd4", 32'(rdata_a), 32'h11);
    tick(); tick();
    chk("abort_still_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(clr_done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      raddr_a = AW'(i);
      #1;
      chk("abort_rd_zero", 32'(rdata_a1), 32'd0);
    end
    tick();
    chk("abort_no_done_later", 32'(clr_done), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
